// File: rtl/ahbl_rr_sched_if.sv
// ahbl_rr_sched_if: bundles the request-side inputs and the grant-side
// outputs of the round-robin grant scheduler.
//   master modport : the bus fabric / requesters (drive req/hold/lock/advance)
//   slave modport  : the scheduler itself (drives the grant outputs)
interface ahbl_rr_sched_if #(
  parameter int N_REQ    = 4,
  parameter int W_IDX    = 2,
  parameter int W_TENURE = 4
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    hold;
  logic [N_REQ-1:0]    lock;
  logic                advance;
  logic [N_REQ-1:0]    gnt;
  logic                gnt_valid;
  logic [W_IDX-1:0]    gnt_idx;
  logic [W_TENURE-1:0] tenure;

  modport master (
    output req, hold, lock, advance,
    input  gnt, gnt_valid, gnt_idx, tenure
  );

  modport slave (
    input  req, hold, lock, advance,
    output gnt, gnt_valid, gnt_idx, tenure
  );
endinterface

// File: rtl/ahbl_rr_sched.sv
// ahbl_rr_sched: round-robin grant scheduler for a shared AHB-Lite slave port.
// Produces a registered one-hot grant that only changes on address-phase
// boundaries (advance). Supports locked sequences (never pre-empted) and
// burst holds bounded by TENURE_MAX consecutive advances.
//
// Optional feature macro: AHBL_RR_SCHED_PARK_EN
//   defined   : with no requests the grant parks on the last owner
//   undefined : with no requests the grant drops to zero (IDLE)
module ahbl_rr_sched #(
  parameter int N_REQ      = 4,
  parameter int W_IDX      = 2,
  parameter int W_TENURE   = 4,
  parameter int TENURE_MAX = 8
) (
  input  logic           clk,
  input  logic           rst,
  ahbl_rr_sched_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  localparam logic [W_IDX-1:0]    LAST_IDX = W_IDX'(N_REQ - 1);
  localparam logic [W_TENURE-1:0] TEN_SAT  = {W_TENURE{1'b1}};
  localparam logic [W_TENURE:0]   TEN_MAX  = (W_TENURE + 1)'(TENURE_MAX);

  state_t              state_reg, state_next;
  logic [W_IDX-1:0]    idx_reg, idx_next;
  logic [W_TENURE-1:0] tenure_reg, tenure_next;
  logic [N_REQ-1:0]    gnt_reg;
  logic                gnt_valid_reg;

  logic [N_REQ-1:0]    gnt_dec;
  logic                found;
  logic [W_IDX-1:0]    win_idx;
  logic [W_IDX-1:0]    cand;
  logic [W_TENURE:0]   tenure_inc;
  logic                own_req;

  // Circular search starting just after the current/last owner, so the
  // owner itself is examined last; the wrap N_REQ-1 -> 0 is explicit.
  always_comb begin
    found   = 1'b0;
    win_idx = idx_reg;
    cand    = (idx_reg == LAST_IDX) ? '0 : idx_reg + W_IDX'(1);
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && bus.req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
      cand = (cand == LAST_IDX) ? '0 : cand + W_IDX'(1);
    end
  end

  assign own_req    = bus.req[idx_reg];
  assign tenure_inc = {1'b0, tenure_reg} + (W_TENURE + 1)'(1);

  // Next-state logic: nothing moves unless the address phase completes.
  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    tenure_next = tenure_reg;
    if (bus.advance) begin
      case (state_reg)
        IDLE: begin
          if (found) begin
            state_next  = OWNED;
            idx_next    = win_idx;
            tenure_next = '0;
          end
        end
        OWNED: begin
          if (own_req && bus.lock[idx_reg]) begin
            // locked sequence: keep owner, count saturates
            tenure_next = (tenure_reg == TEN_SAT) ? TEN_SAT
                                                  : tenure_reg + W_TENURE'(1);
          end else if (own_req && bus.hold[idx_reg] && (tenure_inc < TEN_MAX)) begin
            tenure_next = tenure_reg + W_TENURE'(1);
          end else if (found) begin
            // re-grant to the same owner only happens when nobody else asks
            idx_next    = win_idx;
            tenure_next = '0;
          end else begin
`ifdef AHBL_RR_SCHED_PARK_EN
            // park on the last owner so its next request costs no cycle
            tenure_next = '0;
`else
            state_next  = IDLE;
            tenure_next = '0;
`endif
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // One-hot decode of the next owner index.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_dec
      assign gnt_dec[gi] = (idx_next == W_IDX'(gi));
    end
  endgenerate

  // State and registered grant outputs; reset is synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      idx_reg       <= LAST_IDX;
      tenure_reg    <= '0;
      gnt_reg       <= '0;
      gnt_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      tenure_reg    <= tenure_next;
      gnt_reg       <= (state_next == OWNED) ? gnt_dec : '0;
      gnt_valid_reg <= (state_next == OWNED);
    end
  end

  assign bus.gnt       = gnt_reg;
  assign bus.gnt_valid = gnt_valid_reg;
  assign bus.gnt_idx   = idx_reg;
  assign bus.tenure    = tenure_reg;

endmodule

// File: tb/tb_ahbl_rr_sched.sv
// tb_ahbl_rr_sched: scoreboard bench for ahbl_rr_sched. The stimulus thread
// advances an integer-level reference model and queues the expected outputs;
// a monitor on the falling edge pops and compares them.
module tb_ahbl_rr_sched;
  localparam int N_REQ      = 4;
  localparam int W_IDX      = 2;
  localparam int W_TENURE   = 4;
  localparam int TENURE_MAX = 8;
  localparam int TEN_SAT    = (1 << W_TENURE) - 1;

  typedef struct {
    logic [N_REQ-1:0]    gnt;
    logic                gnt_valid;
    logic [W_IDX-1:0]    gnt_idx;
    logic [W_TENURE-1:0] tenure;
    int                  n;
  } exp_t;

  logic clk;
  logic rst;

  ahbl_rr_sched_if #(.N_REQ(N_REQ), .W_IDX(W_IDX), .W_TENURE(W_TENURE)) bus ();

  ahbl_rr_sched #(
    .N_REQ(N_REQ), .W_IDX(W_IDX), .W_TENURE(W_TENURE), .TENURE_MAX(TENURE_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;
  int   popped = 0;

  // reference model state: owner -1 means no grant
  int m_owner = -1;
  int m_last  = N_REQ - 1;
  int m_ten   = 0;

  function automatic int rr_pick(input int from, input logic [N_REQ-1:0] q);
    for (int d = 1; d <= N_REQ; d++) begin
      int c;
      c = (from + d) % N_REQ;
      if (q[c]) return c;
    end
    return -1;
  endfunction

  function automatic void model_step(input logic r, input logic [N_REQ-1:0] q,
                                     input logic [N_REQ-1:0] h,
                                     input logic [N_REQ-1:0] l, input logic a);
    int w;
    if (r) begin
      m_owner = -1; m_last = N_REQ - 1; m_ten = 0;
      return;
    end
    if (!a) return;
    if (m_owner < 0) begin
      w = rr_pick(m_last, q);
      if (w >= 0) begin m_owner = w; m_last = w; m_ten = 0; end
    end else if (q[m_owner] && l[m_owner]) begin
      m_ten = (m_ten + 1 > TEN_SAT) ? TEN_SAT : m_ten + 1;
    end else if (q[m_owner] && h[m_owner] && (m_ten + 1 < TENURE_MAX)) begin
      m_ten = m_ten + 1;
    end else begin
      w = rr_pick(m_owner, q);
      if (w >= 0) begin
        m_owner = w; m_last = w; m_ten = 0;
      end else begin
`ifdef AHBL_RR_SCHED_PARK_EN
        m_ten = 0;
`else
        m_owner = -1; m_ten = 0;
`endif
      end
    end
  endfunction

  task automatic step(input logic r, input logic [N_REQ-1:0] q,
                      input logic [N_REQ-1:0] h, input logic [N_REQ-1:0] l,
                      input logic a);
    exp_t e;
    rst         = r;
    bus.req     = q;
    bus.hold    = h;
    bus.lock    = l;
    bus.advance = a;
    model_step(r, q, h, l, a);
    e.gnt       = (m_owner >= 0) ? N_REQ'(1 << m_owner) : '0;
    e.gnt_valid = (m_owner >= 0);
    e.gnt_idx   = W_IDX'(m_last);
    e.tenure    = W_TENURE'(m_ten);
    e.n         = pushed;
    @(posedge clk);
    exp_q.push_back(e);
    pushed++;
    #1;
  endtask

  task automatic chk(input string name, input int n, input logic [31:0] act,
                     input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s txn=%0d actual=%0h required=%0h", name, n, act, req_v);
    end
  endtask

  // Monitor: compare the DUT against the oldest expected entry.
  exp_t mon_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      popped++;
      $display("txn %0d: req=%b hold=%b lock=%b adv=%b rst=%b -> gnt=%b idx=%0d ten=%0d",
               mon_e.n, bus.req, bus.hold, bus.lock, bus.advance, rst,
               bus.gnt, bus.gnt_idx, bus.tenure);
      chk("gnt",       mon_e.n, 32'(bus.gnt),       32'(mon_e.gnt));
      chk("gnt_valid", mon_e.n, 32'(bus.gnt_valid), 32'(mon_e.gnt_valid));
      chk("gnt_idx",   mon_e.n, 32'(bus.gnt_idx),   32'(mon_e.gnt_idx));
      chk("tenure",    mon_e.n, 32'(bus.tenure),    32'(mon_e.tenure));
    end
  end

  initial begin
    logic [N_REQ-1:0] rq, rh, rl, lock_vec;
    logic             ra, rr;
    rst = 1'b1;
    bus.req = '0; bus.hold = '0; bus.lock = '0; bus.advance = 1'b0;

    // reset, then plain rotation over all four requesters
    step(1, 4'b0000, 4'b0000, 4'b0000, 0);
    step(1, 4'b1111, 4'b0000, 4'b0000, 1);
    for (int i = 0; i < 6; i++) step(0, 4'b1111, 4'b0000, 4'b0000, 1);

    // tenure-limited hold on requester 0 against requester 2
    step(1, 4'b0000, 4'b0000, 4'b0000, 0);
    for (int i = 0; i < 12; i++) step(0, 4'b0101, 4'b0001, 4'b0000, 1);

    // locked owner 1 for 20 advances, then lock released
    step(1, 4'b0000, 4'b0000, 4'b0000, 0);
    step(0, 4'b0010, 4'b0000, 4'b0000, 1);
    for (int i = 0; i < 20; i++) step(0, 4'b1111, 4'b0000, 4'b0010, 1);
    step(0, 4'b1111, 4'b0000, 4'b0000, 1);

    // advance low while requests change: everything holds
    step(0, 4'b0001, 4'b0000, 4'b0000, 0);
    step(0, 4'b0001, 4'b0000, 4'b0000, 0);
    step(0, 4'b0011, 4'b0000, 4'b0000, 0);
    step(0, 4'b1000, 4'b0000, 4'b0000, 0);
    step(0, 4'b1000, 4'b0000, 4'b0000, 0);
    step(0, 4'b1000, 4'b0000, 4'b0000, 1);

    // owner 2 with requests dropping to zero, then 1001
    step(1, 4'b0000, 4'b0000, 4'b0000, 0);
    step(0, 4'b0100, 4'b0000, 4'b0000, 1);
    step(0, 4'b0000, 4'b0000, 4'b0000, 1);
    step(0, 4'b0000, 4'b0000, 4'b0000, 1);
    step(0, 4'b1001, 4'b0000, 4'b0000, 1);

    // reset in the middle of a locked sequence on owner 3
    step(1, 4'b0000, 4'b0000, 4'b0000, 0);
    step(0, 4'b1000, 4'b0000, 4'b1000, 1);
    step(0, 4'b1111, 4'b0000, 4'b1000, 1);
    step(0, 4'b1111, 4'b0000, 4'b1000, 1);
    step(1, 4'b1111, 4'b0000, 4'b1000, 1);
    step(0, 4'b1111, 4'b0000, 4'b0000, 1);

    // randomized traffic with slowly changing lock and hold patterns
    lock_vec = '0;
    for (int i = 0; i < 600; i++) begin
      rr = ($urandom_range(0, 99) < 2);
      rq = N_REQ'($urandom);
      if ($urandom_range(0, 3) == 0) rq = '0;
      rh = N_REQ'($urandom) & N_REQ'($urandom);
      if ($urandom_range(0, 19) == 0) lock_vec = N_REQ'($urandom) & N_REQ'($urandom);
      rl = lock_vec;
      ra = ($urandom_range(0, 3) != 0);
      step(rr, rq, rh, rl, ra);
    end

    @(negedge clk);
    #1;
    chk("drain", popped, 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahbl_rr_sched.md
Name: ahbl_rr_sched

Overview:
Round-robin grant scheduler for a shared AHB-Lite slave port. It produces a registered one-hot grant that steers a one-hot address/data mux in the bus fabric. It replaces strict priority where fairness is required, e.g. a DMA and a processor sharing SRAM. Grants change only on address-phase boundaries, indicated by `advance` (slave HREADY). The scheduler supports locked sequences and a bounded burst tenure.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- W_IDX, 2, width of grant index; must satisfy 2**W_IDX >= N_REQ.
- W_TENURE, 4, width of tenure counter.
- TENURE_MAX, 8, maximum consecutive advances granted to one requester under `hold`; range 1..2**W_TENURE-1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req  in  N_REQ  requester i has an active transfer (HTRANS[1] of port i).
- hold  in  N_REQ  requester i is mid-burst and wants to keep the grant (tenure-limited).
- lock  in  N_REQ  requester i is in a locked sequence (HMASTLOCK); the grant is never pre-empted.
- advance  in  1  current address phase completes this cycle (dst HREADY).
- gnt  out  N_REQ  registered one-hot grant; all-zero when no owner.
- gnt_valid  out  1  equals |gnt.
- gnt_idx  out  W_IDX  binary index of the owner; holds the last owner when gnt==0.
- tenure  out  W_TENURE  count of advances completed by the current owner.

Behaviour:
- Reset (rst high at a clk edge):
  - gnt=0, gnt_valid=0, gnt_idx=N_REQ-1 (so requester 0 is searched first), tenure=0, state=IDLE.
  - Applies mid-transfer with no exception.
- All outputs are registered. Grant latency is 1 cycle: a decision taken at edge k, on a cycle where advance=1, is visible after edge k.
- When advance=0, gnt, gnt_idx and tenure hold unconditionally, regardless of req, hold or lock.
- State IDLE (gnt==0):
  - On advance=1 with |req: grant the first set req bit, searching circularly from gnt_idx+1 (mod N_REQ).
  - On that grant: tenure<=0, go to OWNED.
  - With no req: stay IDLE.
- State OWNED (owner o = gnt_idx), on advance=1, priority order:
  1. req[o] & lock[o]: keep o; tenure saturates at 2**W_TENURE-1.
  2. req[o] & hold[o] & (tenure+1 < TENURE_MAX): keep o; tenure<=tenure+1.
  3. Otherwise re-arbitrate circularly from o+1, then o+2, and so on, with o searched last.
     - If the winner is o, tenure<=0. Re-grant after tenure expiry is allowed only when no other requester is active.
     - If the winner is a different requester, tenure<=0.
  4. No req at all: gnt<=0, go to IDLE (but see PARK option); gnt_idx retains o.
- Fairness bound: any requester with req held continuously is granted within (N_REQ-1)*TENURE_MAX advances, excluding locked sequences.
- Simultaneous events:
  - lock outranks hold.
  - hold/lock on a non-owner are ignored.
  - req[o] dropping while lock[o]=1 releases the grant as rule 4 or rule 3.
- Requester indices >= N_REQ do not exist. The gnt_idx wrap from N_REQ-1 to 0 is explicit; no modulo by power of two unless N_REQ is a power of two.
- Output invariant: gnt is always one-hot or zero, and gnt[gnt_idx]==gnt_valid.

Optional Feature:
- Macro: AHBL_RR_SCHED_PARK_EN.
- Defined:
  - With no requests, the grant parks on the last owner: gnt stays one-hot and the state stays OWNED with tenure<=0.
  - The parked owner's next request costs zero arbitration cycles.
  - Other requesters are served by rule 3 on the next advance.
- Undefined: behaviour exactly as rule 4 (gnt drops to zero).

Test Plan:
- Reset, then req=4'b1111 with advance=1 every cycle, hold=lock=0 → gnt sequence 0001, 0010, 0100, 1000, 0001; tenure=0 throughout.
- req=4'b0101, hold[0]=1 continuously, TENURE_MAX=8 → gnt=0001 for 8 consecutive advances (tenure 0..7), then 0100 for 1 advance, then 0001 again.
- Owner 1 with lock[1]=1 for 20 advances, req=4'b1111 → gnt=0010 for all 20; tenure saturates at 15; after lock drops, next gnt=0100.
- advance=0 for 5 cycles while req changes 0001→1000 → gnt and tenure unchanged; on the first advance=1, gnt=1000.
- req drops to 0 with owner 2: without PARK_EN, gnt=0000, gnt_idx=2; then req=4'b1001 → gnt=1000. With PARK_EN, gnt stays 0100 while idle.
- rst asserted mid-lock (owner 3) → after the edge, gnt=0, gnt_idx=3, tenure=0; then req=4'b1111 → gnt=0001.
